// File: rtl/noc_pkg.sv
// Shared definitions for the NOC write-request transmit path: header field
// layout, command codes, idle byte and the serializer state encoding.
package noc_pkg;

    localparam logic [2:0] CMD_WREQ = 3'b010;

    // Header byte layout: {alen[7:6], dlen[5:3], cmd[2:0]}
    localparam int unsigned HDR_CMD_LSB  = 0;
    localparam int unsigned HDR_DLEN_LSB = 3;
    localparam int unsigned HDR_ALEN_LSB = 6;

    localparam logic [1:0] HDR_ALEN_1B = 2'b00;
    localparam logic [2:0] HDR_DLEN_8B = 3'b011;

    localparam logic [7:0] IDLE_BYTE  = 8'h00;
    localparam int unsigned DATA_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DID,
        ST_SID,
        ST_ADDR,
        ST_DATA
    } state_t;

    function automatic logic [7:0] make_hdr(input logic [1:0] alen,
                                            input logic [2:0] dlen,
                                            input logic [2:0] cmd);
        logic [7:0] h;
        h = '0;
        h[HDR_ALEN_LSB +: 2] = alen;
        h[HDR_DLEN_LSB +: 3] = dlen;
        h[HDR_CMD_LSB  +: 3] = cmd;
        return h;
    endfunction

endpackage

// File: rtl/noc_word_fifo.sv
// Word buffer between the perm core and the packet serializer. Head entry is
// presented combinationally and only advances on pop. A push while full is
// accepted only when a pop frees the slot on the same edge.
module noc_word_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/noc_tx_wreq.sv
// Packs 64-bit perm-core result words into 12-byte NOC write-request packets
// (HDR, DID, SID, ADDR, D0..D7) and streams them a byte per cycle.
module noc_tx_wreq #(
    parameter logic [7:0]  DEST_ID    = 8'h00,
    parameter logic [7:0]  SRC_ID     = 8'h01,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushout,
    input  logic        firstout,
    input  logic [63:0] dout,
    output logic        stopout,
    output logic        noc_from_dev_ctl,
    output logic [7:0]  noc_from_dev_data
);

    import noc_pkg::*;

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  HDR_BYTE = make_hdr(HDR_ALEN_1B, HDR_DLEN_8B, CMD_WREQ);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    last_idx_q, last_idx_d;
    logic          ovf_q, ovf_d;
    logic          stopout_q, stopout_d;
    logic          ctl_q, ctl_d;
    logic [7:0]    data_q, data_d;

    logic          pop;
    logic          push_acc;
    logic [64:0]   head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic [7:0]    cur_idx;

    noc_word_fifo #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushout),
        .din_i   ({firstout, dout}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign push_acc    = pushout & (~full | pop);
    assign count_after = count + CW'(push_acc) - CW'(pop);
    assign cur_idx     = head[64] ? 8'h00 : last_idx_q + 8'h01;

    // Serializer next-state: walk the packet fields, pop the head on D7.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!empty) state_d = ST_HDR;
            ST_HDR:  state_d = ST_DID;
            ST_DID:  state_d = ST_SID;
            ST_SID:  state_d = ST_ADDR;
            ST_ADDR: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(DATA_BYTES - 1)) begin
                    pop = 1'b1;
                    // A word arriving on the pop edge also keeps the stream going.
                    state_d = (count > CW'(1) || push_acc) ? ST_HDR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output byte for the upcoming state, plus index, overflow and back-pressure.
    always_comb begin
        ctl_d      = 1'b1;
        data_d     = IDLE_BYTE;
        last_idx_d = pop ? cur_idx : last_idx_q;
        ovf_d      = ovf_q | (pushout & ~push_acc);
        stopout_d  = (count_after >= CW'(FIFO_DEPTH - 1));
        unique case (state_d)
            ST_HDR: begin
                ctl_d  = 1'b1;
                data_d = HDR_BYTE;
            end
            ST_DID: begin
                ctl_d  = 1'b0;
                data_d = DEST_ID;
            end
            ST_SID: begin
                ctl_d  = 1'b0;
                data_d = SRC_ID;
            end
            ST_ADDR: begin
                ctl_d  = 1'b0;
                data_d = cur_idx;
            end
            ST_DATA: begin
                ctl_d  = 1'b0;
                data_d = head[{cnt_d, 3'b000} +: 8];
            end
            default: begin
                ctl_d  = 1'b1;
                data_d = IDLE_BYTE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
            ovf_q      <= 1'b0;
            stopout_q  <= 1'b0;
            ctl_q      <= 1'b1;
            data_q     <= IDLE_BYTE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            ovf_q      <= ovf_d;
            stopout_q  <= stopout_d;
            ctl_q      <= ctl_d;
            data_q     <= data_d;
        end
    end

    assign stopout           = stopout_q;
    assign noc_from_dev_ctl  = ctl_q;
    assign noc_from_dev_data = data_q;

endmodule

// File: tb/tb_noc_tx_wreq.sv
// Directed bench for noc_tx_wreq: packet format, back-to-back streaming,
// overflow, index wrap, mid-packet reset and simultaneous push/pop.
module tb_noc_tx_wreq;

    logic        clk;
    logic        rst;
    logic        pushout;
    logic        firstout;
    logic [63:0] dout;
    logic        stopout;
    logic        noc_from_dev_ctl;
    logic [7:0]  noc_from_dev_data;

    int total = 0;
    int bad   = 0;

    noc_tx_wreq #(
        .DEST_ID    (8'h00),
        .SRC_ID     (8'h01),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pushout           (pushout),
        .firstout          (firstout),
        .dout              (dout),
        .stopout           (stopout),
        .noc_from_dev_ctl  (noc_from_dev_ctl),
        .noc_from_dev_data (noc_from_dev_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] wdata(input int unsigned w);
        return {32'hC0DE0000 + w, 32'h12345678 ^ (w * 32'h9E3779B9)};
    endfunction

    // Expected {ctl,data} of byte b of a packet carrying word w at index idx.
    function automatic logic [8:0] exp_byte(input int unsigned b, input logic [7:0] idx,
                                            input logic [63:0] w);
        logic [63:0] s;
        case (b)
            0: return {1'b1, 8'h1A};
            1: return {1'b0, 8'h00};
            2: return {1'b0, 8'h01};
            3: return {1'b0, idx};
            default: begin
                s = w >> ((b - 4) * 8);
                return {1'b0, s[7:0]};
            end
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pushout = 1'b0;
        firstout = 1'b0;
        dout = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pushout = 1'b0;
        firstout = 1'b0;
        dout = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({noc_from_dev_ctl, noc_from_dev_data} !== 9'h100) begin
            bad++;
            $display("FAIL reset_out: got %h want 100", {noc_from_dev_ctl, noc_from_dev_data});
        end
        total++;
        if (stopout !== 1'b0) begin
            bad++;
            $display("FAIL reset_stopout: got %b want 0", stopout);
        end
        total++;
        if (dut.ovf_q !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: ovf=%b count=%0d want 0/0", dut.ovf_q, dut.u_fifo.count_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [8:0]  obs;
        logic [63:0] w0;
        w0 = 64'h0807060504030201;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c == 1 || c == 14) begin
                total++;
                if (obs !== 9'h100) begin
                    bad++;
                    $display("FAIL single_idle c=%0d: got %h want 100", c, obs);
                end
            end else if (c >= 2) begin
                total++;
                if (obs !== exp_byte(c - 2, 8'h00, w0)) begin
                    bad++;
                    $display("FAIL single_byte%0d: got %h want %h", c - 2, obs, exp_byte(c - 2, 8'h00, w0));
                end
            end
            pushout = (c == 0);
            firstout = 1'b1;
            dout = w0;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] obs;
        int unsigned w, b;
        for (int c = 0; c <= 38; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c == 1 || c == 38) begin
                total++;
                if (obs !== 9'h100) begin
                    bad++;
                    $display("FAIL b2b_idle c=%0d: got %h want 100", c, obs);
                end
            end else if (c >= 2) begin
                w = (c - 2) / 12;
                b = (c - 2) % 12;
                total++;
                if (obs !== exp_byte(b, 8'(w), wdata(w))) begin
                    bad++;
                    $display("FAIL b2b_w%0d_b%0d: got %h want %h", w, b, obs, exp_byte(b, 8'(w), wdata(w)));
                end
            end
            pushout = (c < 3);
            firstout = (c == 0);
            dout = wdata(c);
        end
        pushout = 1'b0;
    endtask

    task automatic test_overflow();
        logic [8:0] obs;
        int unsigned w, b;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c >= 1 && c <= 6) begin
                total++;
                if (stopout !== (c >= 3)) begin
                    bad++;
                    $display("FAIL ovf_stopout c=%0d: got %b want %b", c, stopout, c >= 3);
                end
            end
            if (c == 7) begin
                total++;
                if (dut.ovf_q !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_flag: got %b want 1", dut.ovf_q);
                end
            end
            if (c >= 2 && c < 50) begin
                w = (c - 2) / 12;
                b = (c - 2) % 12;
                total++;
                if (obs !== exp_byte(b, 8'(w), wdata(w))) begin
                    bad++;
                    $display("FAIL ovf_w%0d_b%0d: got %h want %h", w, b, obs, exp_byte(b, 8'(w), wdata(w)));
                end
            end
            if (c == 50) begin
                total++;
                if (obs !== 9'h100 || stopout !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_drain: out=%h stopout=%b want 100/0", obs, stopout);
                end
            end
            pushout = (c < 6);
            firstout = (c == 0);
            dout = wdata(c);
        end
        pushout = 1'b0;
    endtask

    task automatic test_index_wrap();
        logic [8:0]  obs;
        int unsigned sent, rx, pos;
        int          cyc;
        sent = 0;
        rx = 0;
        pos = 0;
        cyc = 0;
        while (rx < 257 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (pos == 0) begin
                if (obs === 9'h11A) begin
                    pos = 1;
                end else begin
                    total++;
                    if (obs !== 9'h100) begin
                        bad++;
                        $display("FAIL wrap_gap cyc=%0d: got %h want 100 or 11a", cyc, obs);
                    end
                end
            end else begin
                total++;
                if (obs !== exp_byte(pos, 8'(rx), wdata(rx))) begin
                    bad++;
                    $display("FAIL wrap_w%0d_b%0d: got %h want %h", rx, pos, obs, exp_byte(pos, 8'(rx), wdata(rx)));
                end
                if (pos == 11) begin
                    pos = 0;
                    rx++;
                end else begin
                    pos++;
                end
            end
            if (sent < 257 && !stopout) begin
                pushout = 1'b1;
                firstout = (sent == 0);
                dout = wdata(sent);
                sent++;
            end else begin
                pushout = 1'b0;
            end
        end
        pushout = 1'b0;
        total++;
        if (rx != 257) begin
            bad++;
            $display("FAIL wrap_timeout: got %0d packets want 257", rx);
        end
        total++;
        if (dut.ovf_q !== 1'b0) begin
            bad++;
            $display("FAIL wrap_ovf: got %b want 0", dut.ovf_q);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c >= 2) begin
                total++;
                if (obs !== exp_byte(c - 2, 8'h00, wdata(0))) begin
                    bad++;
                    $display("FAIL rmid_pre_b%0d: got %h want %h", c - 2, obs, exp_byte(c - 2, 8'h00, wdata(0)));
                end
            end
            pushout = (c < 2);
            firstout = (c == 0);
            dout = wdata(c);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({noc_from_dev_ctl, noc_from_dev_data} !== 9'h100 || stopout !== 1'b0) begin
            bad++;
            $display("FAIL rmid_abort: out=%h stopout=%b want 100/0", {noc_from_dev_ctl, noc_from_dev_data}, stopout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({noc_from_dev_ctl, noc_from_dev_data} !== 9'h100 || dut.u_fifo.empty_o !== 1'b1) begin
                bad++;
                $display("FAIL rmid_quiet c=%0d: out=%h empty=%b want 100/1", c,
                         {noc_from_dev_ctl, noc_from_dev_data}, dut.u_fifo.empty_o);
            end
        end
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c == 1 || c == 14) begin
                total++;
                if (obs !== 9'h100) begin
                    bad++;
                    $display("FAIL rmid_idle c=%0d: got %h want 100", c, obs);
                end
            end else if (c >= 2) begin
                total++;
                if (obs !== exp_byte(c - 2, 8'h00, wdata(7))) begin
                    bad++;
                    $display("FAIL rmid_post_b%0d: got %h want %h", c - 2, obs, exp_byte(c - 2, 8'h00, wdata(7)));
                end
            end
            pushout = (c == 0);
            firstout = 1'b1;
            dout = wdata(7);
        end
        pushout = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [8:0] obs;
        int unsigned w, b;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            obs = {noc_from_dev_ctl, noc_from_dev_data};
            if (c == 13 || c == 14) begin
                total++;
                if (stopout !== 1'b1 || dut.u_fifo.count_o !== 3'd3) begin
                    bad++;
                    $display("FAIL pp_level c=%0d: stopout=%b count=%0d want 1/3", c, stopout, dut.u_fifo.count_o);
                end
            end
            if (c >= 2 && c < 50) begin
                w = (c - 2) / 12;
                b = (c - 2) % 12;
                total++;
                if (obs !== exp_byte(b, 8'(w), wdata(w))) begin
                    bad++;
                    $display("FAIL pp_w%0d_b%0d: got %h want %h", w, b, obs, exp_byte(b, 8'(w), wdata(w)));
                end
            end
            if (c == 50) begin
                total++;
                if (obs !== 9'h100 || dut.ovf_q !== 1'b0) begin
                    bad++;
                    $display("FAIL pp_end: out=%h ovf=%b want 100/0", obs, dut.ovf_q);
                end
            end
            pushout = (c < 3 || c == 13);
            firstout = (c == 0);
            dout = wdata(c < 3 ? c : 3);
        end
        pushout = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_back_to_back();
        do_reset();
        test_overflow();
        do_reset();
        test_index_wrap();
        do_reset();
        test_reset_mid();
        do_reset();
        test_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
